// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - multi-cycle load/store initiator for a registered-address data memory
// Sub-word stores are read-modify-write; sub-word loads are lane-selected and extended.
module dmem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_ISSUE_W,
    S_RESP
  } state_t;

  state_t          r_state;
  logic            r_write;
  logic [1:0]      r_size;
  logic            r_signed;
  logic [1:0]      r_off;
  logic [15:0]     r_wdata;

  logic                  w_accept;
  logic                  w_illegal;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_ext;
  logic [DATA_WIDTH-1:0] w_merged;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_illegal = (req_size == 2'd3) ||
                     (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  // Little-endian lane pick from the word returned in CAPTURE.
  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (r_size)
      2'd0:    w_load_ext = {{(DATA_WIDTH-8){r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load_ext = {{(DATA_WIDTH-16){r_signed & w_half[15]}}, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = mem_rdata;
    if (r_size == 2'd0)
      w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_off      <= 2'd0;
      r_wdata    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata[15:0];
            if (w_illegal) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
              r_state    <= S_RESP;
            end else begin
              mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_write && req_size == 2'd2) begin
                mem_wdata <= req_wdata;
                mem_we    <= 1'b1;
              end else begin
                mem_we <= 1'b0;
              end
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          mem_we <= 1'b0;
          if (r_write && r_size == 2'd2) begin
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            r_state    <= S_RESP;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (!r_write) begin
            resp_rdata <= w_load_ext;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            r_state    <= S_RESP;
          end else begin
            mem_wdata <= w_merged;
            mem_we    <= 1'b1;
            r_state   <= S_ISSUE_W;
          end
        end
        S_ISSUE_W: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
